// File: rtl/core_interrupt_controller.sv
// Parametrised interrupt controller: IE/IF SFR pair, per-source edge/level
// detection, request, fixed-priority vector and sleep wake-up for the core FSM.

module core_int_src_det #(
   parameter logic EDGE = 1'b1,
   parameter logic RISE = 1'b1
) (
   input  logic i_src,
   input  logic i_prev,
   output logic o_ev
);
   logic w_edge_ev;
   logic w_lvl_ev;

   // RISE selects polarity for both modes: rising/active-high vs falling/active-low
   assign w_edge_ev = RISE ? (i_src & ~i_prev) : (~i_src & i_prev);
   assign w_lvl_ev  = (i_src == RISE);
   assign o_ev      = EDGE ? w_edge_ev : w_lvl_ev;
endmodule

module core_interrupt_controller #(
   parameter int                   DATA_WIDTH = 8,
   parameter int                   NUM_SRC    = 4,
   parameter int                   VEC_WIDTH  = 3,
   parameter logic [NUM_SRC-1:0]   EDGE_MASK  = 4'b0111,
   parameter logic [NUM_SRC-1:0]   RISE_MASK  = 4'b1111,
   parameter logic [DATA_WIDTH-1:0] IE_RESET  = 8'h00,
   parameter logic [DATA_WIDTH-1:0] IF_RESET  = 8'h00
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_WIDTH-1:0] i_d,
   input  logic                  i_ie_wr_en,
   input  logic                  i_if_wr_en,
   input  logic                  i_gie_clr_en,
   input  logic                  i_gie_set_en,
   input  logic [NUM_SRC-1:0]    i_src_in,
   output logic [DATA_WIDTH-1:0] o_ie_q,
   output logic [DATA_WIDTH-1:0] o_if_q,
   output logic                  o_gie,
   output logic                  o_irq_req,
   output logic [VEC_WIDTH-1:0]  o_irq_vec,
   output logic                  o_wake
);
   localparam int MSB = DATA_WIDTH - 1;

   logic [DATA_WIDTH-1:0] r_ie;
   logic [NUM_SRC-1:0]    r_if;
   logic [NUM_SRC-1:0]    r_src_prev;
   logic [NUM_SRC-1:0]    w_ev;
   logic [NUM_SRC-1:0]    w_if_nxt;
   logic [NUM_SRC-1:0]    w_pend;
   logic [VEC_WIDTH-1:0]  w_vec;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      core_int_src_det #(
         .EDGE (EDGE_MASK[g]),
         .RISE (RISE_MASK[g])
      ) u_det (
         .i_src  (i_src_in[g]),
         .i_prev (r_src_prev[g]),
         .o_ev   (w_ev[g])
      );
   end

   // Hardware set wins over a software write, so no event is ever lost
   assign w_if_nxt = w_ev | (i_if_wr_en ? i_d[NUM_SRC-1:0] : r_if);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ie       <= IE_RESET;
         r_if       <= IF_RESET[NUM_SRC-1:0];
         r_src_prev <= ~RISE_MASK;
      end else begin
         r_src_prev <= i_src_in;
         r_if       <= w_if_nxt;
         if (i_ie_wr_en)
            r_ie[MSB-1:0] <= i_d[MSB-1:0];
         if (i_gie_clr_en)
            r_ie[MSB] <= 1'b0;
         else if (i_gie_set_en)
            r_ie[MSB] <= 1'b1;
         else if (i_ie_wr_en)
            r_ie[MSB] <= i_d[MSB];
      end
   end

   assign w_pend = r_ie[NUM_SRC-1:0] & r_if;

   // Source 0 is highest priority: scan downward so the lowest index lands last
   always_comb begin
      w_vec = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (w_pend[i])
            w_vec = VEC_WIDTH'(i);
   end

   assign o_ie_q    = r_ie;
   assign o_if_q    = {{(DATA_WIDTH-NUM_SRC){1'b0}}, r_if};
   assign o_gie     = r_ie[MSB];
   assign o_wake    = |w_pend;
   assign o_irq_req = r_ie[MSB] & (|w_pend);
   assign o_irq_vec = w_vec;
endmodule
